// File: rtl/spi_cpu_pkg.sv
// ----------------------------------------------------------------------------
// spi_cpu_pkg
// Shared constants and state type for the SPI instruction loader.
//   OPCODE_W   : opcode width
//   OPERAND_W  : operand width (2x opcode)
//   FRAME_BITS : bits per instruction frame
//   RESULT_W   : execution-unit readback width
// ----------------------------------------------------------------------------
package spi_cpu_pkg;

    localparam int OPCODE_W   = 4;
    localparam int OPERAND_W  = 8;
    localparam int FRAME_BITS = 12;
    localparam int RESULT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// ----------------------------------------------------------------------------
// spi_pin_sync
// Multi-flop synchroniser for one asynchronous pin, plus rise/fall detect on
// the synchronised level.
//   clk     in  core clock
//   reset   in  synchronous active-high reset
//   i_pin   in  asynchronous pin
//   o_sync  out synchronised level (STAGES clk edges behind the pin)
//   o_rise  out one-cycle pulse when o_sync goes 0->1
//   o_fall  out one-cycle pulse when o_sync goes 1->0
// RST_VAL sets the idle level the chain resets to, so a pin already at its
// idle level produces no spurious edge when reset releases.
// ----------------------------------------------------------------------------
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_pin};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise =  o_sync & ~r_prev;
    assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/spi_instruction_loader.sv
// ----------------------------------------------------------------------------
// spi_instruction_loader
// SPI mode-0 slave that deserialises 12-bit instruction frames (MSB first)
// into opcode/operand and pulses start once per complete frame. All logic is
// in the clk domain; SPI pins are oversampled through spi_pin_sync.
//
// Ports:
//   clk          in  core clock
//   reset        in  synchronous active-high reset
//   spi_sclk     in  SPI clock (CPOL=0, CPHA=0), asynchronous
//   spi_cs_n     in  active-low chip select
//   spi_mosi     in  serial data in, MSB first
//   spi_miso     out serial readback data (0 when idle / readback absent)
//   cpu_out      in  execution-unit result returned on MISO
//   opcode       out last complete opcode, held
//   operand      out last complete operand, held
//   start        out one-cycle strobe per complete frame
//   frame_error  out one-cycle strobe when cs_n closes a partial frame
//
// Build option: define SPI_READBACK_EN to return cpu_out on spi_miso.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs_n high; sclk edges ignored
// SHIFT | cs_n low; shifting mosi on sclk rise, counting frame bits
// ----------------------------------------------------------------------------
module spi_instruction_loader
    import spi_cpu_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = OPCODE_W,
    parameter int OUTPUT_DATA_WIDTH = RESULT_W,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sclk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    input  logic [OUTPUT_DATA_WIDTH-1:0]  cpu_out,
    output logic [INPUT_DATA_WIDTH-1:0]   opcode,
    output logic [2*INPUT_DATA_WIDTH-1:0] operand,
    output logic                          start,
    output logic                          frame_error
);

    localparam int FRAME = 3 * INPUT_DATA_WIDTH;
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
    logic w_cs_rise, w_cs_fall, w_cs_lvl_unused;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (spi_sclk),
        .o_sync (w_sclk_lvl_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (spi_cs_n),
        .o_sync (w_cs_lvl_unused),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (spi_mosi),
        .o_sync (w_mosi),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    state_t                        r_state, w_state_nx;
    logic [CNT_W-1:0]              r_cnt, w_cnt_nx;
    logic [FRAME-2:0]              r_shift, w_shift_nx;
    logic [INPUT_DATA_WIDTH-1:0]   r_opcode;
    logic [2*INPUT_DATA_WIDTH-1:0] r_operand;
    logic                          r_start, w_start_nx;
    logic                          r_err, w_err_nx;
    logic                          w_load, w_open, w_wrap;
    logic [FRAME-1:0]              w_frame;

    // The bit completing the frame is taken straight from the synchroniser so
    // the outputs update on the same edge as the counter wrap.
    assign w_frame = {r_shift, w_mosi};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_start <= w_start_nx;
            r_err   <= w_err_nx;
            if (w_load) begin
                r_opcode  <= w_frame[FRAME-1 -: INPUT_DATA_WIDTH];
                r_operand <= w_frame[2*INPUT_DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_start_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_load     = 1'b0;
        w_open     = 1'b0;
        w_wrap     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx = SHIFT;
                    w_cnt_nx   = '0;
                    w_shift_nx = '0;
                    w_open     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    if (r_cnt == LAST) begin
                        w_cnt_nx   = '0;
                        w_shift_nx = '0;
                        w_load     = 1'b1;
                        w_start_nx = 1'b1;
                        w_wrap     = 1'b1;
                    end else begin
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                        w_shift_nx = {r_shift[FRAME-3:0], w_mosi};
                    end
                end
                // Close is judged on the post-shift count, so a 12th bit
                // landing in the same cycle as cs_n rise still completes.
                if (w_cs_rise) begin
                    w_err_nx   = (w_cnt_nx != '0);
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_shift_nx = '0;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign start       = r_start;
    assign frame_error = r_err;

`ifdef SPI_READBACK_EN
    localparam int TXC_W = $clog2(OUTPUT_DATA_WIDTH + 1);
    localparam logic [TXC_W-1:0] TX_DONE = TXC_W'(OUTPUT_DATA_WIDTH);

    logic [OUTPUT_DATA_WIDTH-1:0] r_tx;
    logic [TXC_W-1:0]             r_tx_cnt;
    logic                         r_tx_skip;

    // A wrap reloads tx on the 12th rise; the sclk fall that follows belongs
    // to the new frame's first bit and must not shift it away.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx      <= '0;
            r_tx_cnt  <= '0;
            r_tx_skip <= 1'b0;
        end else if (w_open || w_wrap) begin
            r_tx      <= cpu_out;
            r_tx_cnt  <= '0;
            r_tx_skip <= w_wrap;
        end else if (r_state == SHIFT && w_sclk_fall) begin
            if (r_tx_skip) begin
                r_tx_skip <= 1'b0;
            end else if (r_tx_cnt != TX_DONE) begin
                r_tx     <= r_tx << 1;
                r_tx_cnt <= r_tx_cnt + TXC_W'(1);
            end
        end
    end

    assign spi_miso = (r_state == SHIFT) && (r_tx_cnt != TX_DONE)
                      && r_tx[OUTPUT_DATA_WIDTH-1];
`else
    logic w_cpu_out_unused;
    assign w_cpu_out_unused = ^cpu_out;
    assign spi_miso = 1'b0;
`endif

endmodule

// File: doc/spi_instruction_loader.md
# spi_instruction_loader

SPI slave front end that deserialises 12-bit instruction frames from an external host and issues them to the CPU execution unit as `opcode`/`operand` with a one-cycle `start` strobe. It sits between the chip's SPI pins and the execution unit, running entirely in the core `clk` domain by oversampling the SPI pins. With readback compiled in, it also returns the execution unit's 8-bit result to the host on MISO during the next frame.

## Interface
- `INPUT_DATA_WIDTH`, 4, opcode width; operand is 2× this; frame length is 3× this.
- `OUTPUT_DATA_WIDTH`, 8, width of `cpu_out` readback word.
- `SYNC_STAGES`, 2, synchroniser depth on `spi_sclk`/`spi_cs_n`/`spi_mosi` (≥2).
- `clk`  in  1  core clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `spi_cs_n`  in  1  active-low chip select.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out; 0 when idle or readback disabled.
- `cpu_out`  in  OUTPUT_DATA_WIDTH  execution-unit result for readback.
- `opcode`  out  INPUT_DATA_WIDTH  last complete instruction opcode, held.
- `operand`  out  2*INPUT_DATA_WIDTH  last complete instruction operand, held.
- `start`  out  1  one-cycle strobe per complete frame.
- `frame_error`  out  1  one-cycle strobe when a frame is aborted mid-way.

## Operation
- Pins pass through SYNC_STAGES flops; edge detect on synchronised `sclk` (rise/fall) and `cs_n` (fall = frame open, rise = frame close).
- Frame: 12 bits MSB first; bits 11..8 → `opcode`, bits 7..0 → `operand`.
- States: IDLE (cs_n high), SHIFT (cs_n low, counting). IDLE→SHIFT on cs_n fall: bit counter cleared, shift register cleared. SHIFT→IDLE on cs_n rise.
- On each sclk rise in SHIFT: shift in synchronised mosi, counter +1.
- On the 12th bit: `opcode`/`operand` load from {shift[10:0], mosi}; `start`=1 for one cycle; counter wraps to 0, remaining in SHIFT — back-to-back frames under one cs_n assertion are legal.
- cs_n rise with counter ≠ 0: partial bits discarded, outputs unchanged, no `start`, `frame_error`=1 one cycle. cs_n rise with counter = 0: no error.
- sclk edges while IDLE ignored.
- Reset (any time, including mid-frame): state IDLE, counter 0, shift register 0, `opcode`=0, `operand`=0, `start`=0, `frame_error`=0, `spi_miso`=0, tx register 0.

## Timing
- Latency: `start` and new `opcode`/`operand` become visible after the clk edge SYNC_STAGES edges after the edge where stage 1 first samples bit-11 sclk high (2 edges at default).
- `opcode`/`operand` change only in the same cycle `start` rises; stable otherwise.
- Minimum sclk high and low time: 2 clk periods each (fsclk ≤ fclk/4).
- mosi must be stable from sclk rise minus 1 clk to sclk rise plus SYNC_STAGES+1 clk.
- Simultaneous 12th sclk rise and cs_n rise in one cycle: frame completes (`start`=1), no `frame_error`.

## Configuration
- `SPI_READBACK_EN` defined: at cs_n fall and at every 12-bit wrap, `cpu_out` is latched into the tx register; `spi_miso` drives tx MSB, advancing one bit on each sclk fall; after OUTPUT_DATA_WIDTH bits it drives 0 for the remainder of the frame; 0 in IDLE.
- Undefined: no tx register; `spi_miso` tied 0; `cpu_out` ignored.

## Structure
- Shared package `spi_cpu_pkg`: `OPCODE_W`=4, `OPERAND_W`=8, `FRAME_BITS`=12, `RESULT_W`=8, state enum {IDLE, SHIFT}.
- One sub-module: `spi_pin_sync` — per-bit synchroniser chain plus rise/fall detect, instantiated for sclk, cs_n, and mosi (data only).

## Test plan
- Single frame 0xA5C (cs_n low, 12 bits, cs_n high) → one `start` pulse; `opcode`=0xA, `operand`=0x5C; no `frame_error`.
- Two frames 0x312, 0xFFF under one cs_n → two `start` pulses; final `opcode`=0xF, `operand`=0xFF.
- Abort after 7 bits → `frame_error` one cycle, no `start`, outputs keep previous 0xA/0x5C.
- `reset` asserted after bit 6 and released, then a full frame 0x101 → outputs 0 during reset; after it, `opcode`=0x1, `operand`=0x01, exactly one `start`.
- Readback enabled, `cpu_out`=0xC3 at cs_n fall → MISO shows 1,1,0,0,0,0,1,1 then 0,0,0,0 across 12 sclk; disabled → MISO constantly 0.
- sclk toggling with cs_n high → no `start`, no `frame_error`, outputs unchanged.
